// File: rtl/mult_share_arbiter_if.sv
// Request/operand and result/status bundle shared by the two clients and the
// shift-add multiplier.
interface mult_share_arbiter_if #(
  parameter int WIDTH = 4
);
  logic                 req0;
  logic [WIDTH-1:0]     a0;
  logic [WIDTH-1:0]     b0;
  logic                 req1;
  logic [WIDTH-1:0]     a1;
  logic [WIDTH-1:0]     b1;
  logic                 busy;
  logic                 owner;
  logic [2*WIDTH-1:0]   product;
  logic                 done0;
  logic                 done1;

  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  busy, owner, product, done0, done1
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output busy, owner, product, done0, done1
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Two-client round-robin arbiter in front of one sequential shift-add
// multiplier: one add-and-shift step per clock, registered result and done pulse.
module mult_share_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mult_share_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [PW-1:0]      mcand_q, mcand_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]      product_q, product_d;
  logic               done0_q, done0_d;
  logic               done1_q, done1_d;

  logic               winner;
  logic [PW-1:0]      step_sum;

  // On a tie the requester not served last wins; otherwise the lone requester.
  assign winner   = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
  assign step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    mplier_d  = mplier_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          owner_d  = winner;
          last_d   = winner;
          mplier_d = winner ? bus.a1 : bus.a0;
          mcand_d  = {{WIDTH{1'b0}}, (winner ? bus.b1 : bus.b0)};
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d    = step_sum;
        mplier_d = mplier_q >> 1;
        mcand_d  = mcand_q << 1;
        cnt_d    = cnt_q + 1'b1;
        // Last step: publish the sum that includes this step's partial product.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          product_d = step_sum;
          done0_d   = ~owner_q;
          done1_d   = owner_q;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      mplier_q  <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      mplier_q  <= mplier_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.owner   = owner_q;
  assign bus.product = product_q;
  assign bus.done0   = done0_q;
  assign bus.done1   = done1_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: vector table, directed multi-cycle sequences,
// then random traffic against a timestamp-level reference model.
module tb_mult_share_arbiter;
  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   ecount;

  mult_share_arbiter_if #(.WIDTH(W)) bus ();

  mult_share_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          sel;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [7:0]  exp_p;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
    ecount++;
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Reference model: schedule-based, tracks only grant time, owner and product.
  bit model_active;
  int model_g;
  bit model_last;
  bit model_owner;
  int model_prod;
  int model_pend;

  task automatic model_edge(input int k, input bit rs, input bit r0, input bit r1,
                            input int ma0, input int mb0, input int ma1, input int mb1);
    bit w;
    if (!rs) begin
      model_active = 0; model_last = 1; model_owner = 0; model_prod = 0;
    end else begin
      if (model_active && k == model_g + W) model_prod = model_pend;
      if ((!model_active || k >= model_g + W + 2) && (r0 || r1)) begin
        w = (r0 && r1) ? !model_last : r1;
        model_active = 1; model_g = k; model_owner = w; model_last = w;
        model_pend = w ? ma1 * mb1 : ma0 * mb0;
      end
    end
  endtask

  task automatic rtick(input int k);
    bit rs, r0, r1;
    int ma0, mb0, ma1, mb1;
    bit eb, e0, e1;
    rs = rst_n; r0 = bus.req0; r1 = bus.req1;
    ma0 = int'(bus.a0); mb0 = int'(bus.b0); ma1 = int'(bus.a1); mb1 = int'(bus.b1);
    tick();
    model_edge(k, rs, r0, r1, ma0, mb0, ma1, mb1);
    eb = model_active && k >= model_g && k <= model_g + W;
    e0 = model_active && k == model_g + W && !model_owner;
    e1 = model_active && k == model_g + W && model_owner;
    chk("rnd_busy", 16'(bus.busy), 16'(eb));
    chk("rnd_owner", 16'(bus.owner), 16'(model_owner));
    chk("rnd_product", 16'(bus.product), 16'(model_prod));
    chk("rnd_done0", 16'(bus.done0), 16'(e0));
    chk("rnd_done1", 16'(bus.done1), 16'(e1));
  endtask

  initial begin
    int n;
    int busy_cnt;
    total = 0; bad = 0; ecount = 0;

    vt[0] = '{sel: 1'b0, a: 4'd11, b: 4'd12, exp_p: 8'd132};
    vt[1] = '{sel: 1'b1, a: 4'd15, b: 4'd15, exp_p: 8'd225};
    vt[2] = '{sel: 1'b1, a: 4'd0,  b: 4'd6,  exp_p: 8'd0};
    vt[3] = '{sel: 1'b1, a: 4'd6,  b: 4'd0,  exp_p: 8'd0};
    vt[4] = '{sel: 1'b1, a: 4'd7,  b: 4'd1,  exp_p: 8'd7};
    vt[5] = '{sel: 1'b0, a: 4'd15, b: 4'd1,  exp_p: 8'd15};
    vt[6] = '{sel: 1'b0, a: 4'd1,  b: 4'd15, exp_p: 8'd15};
    vt[7] = '{sel: 1'b0, a: 4'd9,  b: 4'd13, exp_p: 8'd117};

    idle_inputs();
    do_reset();
    chk("rst_busy", 16'(bus.busy), 16'd0);
    chk("rst_owner", 16'(bus.owner), 16'd0);
    chk("rst_product", 16'(bus.product), 16'd0);
    chk("rst_done0", 16'(bus.done0), 16'd0);
    chk("rst_done1", 16'(bus.done1), 16'd0);

    // Single operations; req dropped right after grant, operands scrambled.
    foreach (vt[i]) begin
      if (vt[i].sel) begin bus.req1 = 1'b1; bus.a1 = vt[i].a; bus.b1 = vt[i].b; end
      else           begin bus.req0 = 1'b1; bus.a0 = vt[i].a; bus.b0 = vt[i].b; end
      tick();
      busy_cnt = bus.busy ? 1 : 0;
      chk("vec_grant_busy", 16'(bus.busy), 16'd1);
      chk("vec_owner", 16'(bus.owner), 16'(vt[i].sel));
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      bus.a0 = 4'($urandom); bus.b0 = 4'($urandom);
      bus.a1 = 4'($urandom); bus.b1 = 4'($urandom);
      n = 0;
      while (!(bus.done0 | bus.done1) && n < 20) begin
        tick(); n++;
        if (bus.busy) busy_cnt++;
      end
      chk("vec_latency", 16'(n), 16'd4);
      chk("vec_product", 16'(bus.product), 16'(vt[i].exp_p));
      chk("vec_done0", 16'(bus.done0), 16'(!vt[i].sel));
      chk("vec_done1", 16'(bus.done1), 16'(vt[i].sel));
      tick();
      chk("vec_done_clear", 16'({bus.done0, bus.done1}), 16'd0);
      chk("vec_busy_len", 16'(busy_cnt), 16'd5);
      tick();
      chk("vec_no_restart", 16'(bus.busy), 16'd0);
      chk("vec_product_hold", 16'(bus.product), 16'(vt[i].exp_p));
    end

    // Tie from reset with both requests held: alternate 0,1,0,1 at 6-cycle spacing.
    idle_inputs();
    do_reset();
    bus.req0 = 1'b1; bus.a0 = 4'd10; bus.b0 = 4'd10;
    bus.req1 = 1'b1; bus.a1 = 4'd5;  bus.b1 = 4'd3;
    tick();
    chk("tie_first_owner", 16'(bus.owner), 16'd0);
    for (int op = 0; op < 4; op++) begin
      n = 0;
      do begin
        tick(); n++;
        chk("tie_no_overlap", 16'(bus.done0 & bus.done1), 16'd0);
      end while (!(bus.done0 | bus.done1) && n < 20);
      chk("tie_spacing", 16'(n), (op == 0) ? 16'd4 : 16'd6);
      chk("tie_done0", 16'(bus.done0), 16'(op % 2 == 0));
      chk("tie_done1", 16'(bus.done1), 16'(op % 2 == 1));
      chk("tie_product", 16'(bus.product), (op % 2 == 0) ? 16'd100 : 16'd15);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick(); tick();
    chk("tie_stops", 16'(bus.busy), 16'd0);

    // Arrival while busy: req1 waits, its operands are taken at the grant edge.
    idle_inputs();
    tick();
    bus.req0 = 1'b1; bus.a0 = 4'd3; bus.b0 = 4'd4;
    for (int e = 0; e <= 10; e++) begin
      tick();
      case (e)
        0: begin
          chk("arr_grant0_owner", 16'(bus.owner), 16'd0);
          bus.req0 = 1'b0;
        end
        1: begin bus.req1 = 1'b1; bus.a1 = 4'd2; bus.b1 = 4'd2; end
        3: begin bus.a1 = 4'd9; bus.b1 = 4'd9; end
        4: begin
          chk("arr_done0", 16'(bus.done0), 16'd1);
          chk("arr_product0", 16'(bus.product), 16'd12);
          chk("arr_done1_quiet", 16'(bus.done1), 16'd0);
        end
        5: begin
          chk("arr_idle_gap", 16'(bus.busy), 16'd0);
          bus.a1 = 4'd13; bus.b1 = 4'd11;
        end
        6: begin
          chk("arr_grant1_busy", 16'(bus.busy), 16'd1);
          chk("arr_grant1_owner", 16'(bus.owner), 16'd1);
          bus.a1 = 4'd0; bus.b1 = 4'd0; bus.req1 = 1'b0;
        end
        10: begin
          chk("arr_done1", 16'(bus.done1), 16'd1);
          chk("arr_product1", 16'(bus.product), 16'd143);
          chk("arr_done0_quiet", 16'(bus.done0), 16'd0);
        end
        default: ;
      endcase
    end
    tick();

    // Reset in the middle of CALC: no done pulse, cleared outputs, pointer back to 1.
    bus.req0 = 1'b1; bus.a0 = 4'd15; bus.b0 = 4'd15;
    tick();
    bus.req0 = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_busy", 16'(bus.busy), 16'd0);
    chk("mid_rst_product", 16'(bus.product), 16'd0);
    chk("mid_rst_owner", 16'(bus.owner), 16'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("mid_rst_no_done", 16'({bus.done0, bus.done1}), 16'd0);
    end
    bus.req0 = 1'b1; bus.a0 = 4'd2; bus.b0 = 4'd3;
    bus.req1 = 1'b1; bus.a1 = 4'd4; bus.b1 = 4'd5;
    tick();
    chk("post_rst_tie_owner", 16'(bus.owner), 16'd0);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    n = 0;
    while (!(bus.done0 | bus.done1) && n < 20) begin tick(); n++; end
    chk("post_rst_done0", 16'(bus.done0), 16'd1);
    chk("post_rst_product", 16'(bus.product), 16'd6);
    tick(); tick();

    // Random traffic against the reference model, occasional resets.
    idle_inputs();
    rst_n = 1'b0;
    for (int k = 0; k < 600; k++) begin
      rtick(k);
      rst_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      bus.req0 = ($urandom_range(0, 99) < 45);
      bus.req1 = ($urandom_range(0, 99) < 45);
      bus.a0 = 4'($urandom); bus.b0 = 4'($urandom);
      bus.a1 = 4'($urandom); bus.b1 = 4'($urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
